// File: rtl/axi4_dram_responder_if.sv
// AXI4 bus bundle between the team's AXI4 master and the DRAM responder.
// Clock and reset stay outside the bundle as plain ports.
interface axi4_dram_responder_if #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 512,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [15:0]                 awid;
  logic [1:0]                  awburst;
  logic [2:0]                  awsize;
  logic [7:0]                  awlen;
  logic [15:0]                 awuser;
  logic                        awvalid;
  logic                        awready;

  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_STROBE_WIDTH-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic [15:0]                 bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [15:0]                 arid;
  logic [1:0]                  arburst;
  logic [2:0]                  arsize;
  logic [7:0]                  arlen;
  logic [15:0]                 aruser;
  logic                        arvalid;
  logic                        arready;

  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [15:0]                 rid;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awid, awburst, awsize, awlen, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arburst, arsize, arlen, aruser, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awburst, awsize, awlen, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arburst, arsize, arlen, aruser, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_dram_responder.sv
// AXI4 slave that models DRAM with an internal word array; independent
// single-outstanding write (AW/W/B) and read (AR/R) state machines.
module axi4_dram_responder #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 512,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter int AXI_STROBE_LEN   = $clog2(AXI_STROBE_WIDTH),
  parameter int MEM_DEPTH        = 256
) (
  input logic                  s_axi_aclk,
  input logic                  s_axi_aresetn,
  axi4_dram_responder_if.slave s_axi
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AIDX_W = AXI_ADDR_WIDTH - AXI_STROBE_LEN;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index with a sticky overflow bit on top.
  typedef logic [IDX_W:0] idx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic idx_t addr_to_idx(input logic [AIDX_W-1:0] word);
    return {word >= AIDX_W'(MEM_DEPTH), word[IDX_W-1:0]};
  endfunction

  // INCR past the top sets the overflow bit instead of wrapping to word 0.
  function automatic idx_t idx_next(input idx_t idx);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx[IDX_W-1:0]} + (IDX_W+1)'(1);
    return {idx[IDX_W] | sum[IDX_W], sum[IDX_W-1:0]};
  endfunction

  function automatic logic idx_in_range(input idx_t idx);
    return !idx[IDX_W] && ({1'b0, idx[IDX_W-1:0]} < (IDX_W+1)'(MEM_DEPTH));
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write
  w_state_t    w_state_q, w_state_d;
  logic [15:0] w_id_q;
  idx_t        w_idx_q;
  logic        w_fixed_q, w_size_ok_q, w_err_q;
  logic [7:0]  w_len_q, w_cnt_q;
  logic        aw_hs, w_beat, w_beat_ok;

  assign aw_hs     = (w_state_q == W_IDLE) && s_axi.awvalid;
  assign w_beat    = (w_state_q == W_DATA) && s_axi.wvalid;
  assign w_beat_ok = idx_in_range(w_idx_q) && w_size_ok_q;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, like real flops.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) w_state_q <= W_IDLE;
    else                w_state_q <= w_state_d;
  end

  // NOTE: outputs and next state get defaults before the case so no path
  // leaves them unassigned, which would infer latches.
  always_comb begin
    w_state_d     = w_state_q;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && s_axi.wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_id_q      <= '0;
      w_idx_q     <= '0;
      w_fixed_q   <= 1'b0;
      w_size_ok_q <= 1'b0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_err_q     <= 1'b0;
    end else if (aw_hs) begin
      w_id_q      <= s_axi.awid;
      w_idx_q     <= addr_to_idx(s_axi.awaddr[AXI_ADDR_WIDTH-1:AXI_STROBE_LEN]);
      w_fixed_q   <= (s_axi.awburst == 2'b00);
      w_size_ok_q <= (s_axi.awsize == 3'(AXI_STROBE_LEN));
      w_len_q     <= s_axi.awlen;
      w_cnt_q     <= '0;
      w_err_q     <= 1'b0;
    end else if (w_beat) begin
      // Early wlast, or running past len without wlast, both poison the burst.
      if (!w_beat_ok || (s_axi.wlast ? (w_cnt_q != w_len_q) : (w_cnt_q == w_len_q)))
        w_err_q <= 1'b1;
      if (w_cnt_q != w_len_q) w_cnt_q <= w_cnt_q + 8'd1;
      if (!w_fixed_q)         w_idx_q <= idx_next(w_idx_q);
    end
  end

  // NOTE: the array has no reset; contents survive reset and start unknown.
  always_ff @(posedge s_axi_aclk) begin
    if (w_beat && w_beat_ok) begin
      for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_q[IDX_W-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.bid   = w_id_q;
  assign s_axi.bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // ----------------------------------------------------------------- read
  r_state_t                  r_state_q, r_state_d;
  logic [15:0]               r_id_q, rid_q;
  idx_t                      r_idx_q;
  logic                      r_fixed_q, r_size_ok_q;
  logic [7:0]                r_len_q, r_cnt_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;
  logic                      rlast_q;
  logic                      ar_hs, r_hs;

  assign ar_hs = (r_state_q == R_IDLE) && s_axi.arvalid;
  assign r_hs  = (r_state_q == R_DATA) && s_axi.rready;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state_q <= R_IDLE;
    else                r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d     = r_state_q;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) r_state_d = rlast_q ? R_IDLE : R_FETCH;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_id_q      <= '0;
      r_idx_q     <= '0;
      r_fixed_q   <= 1'b0;
      r_size_ok_q <= 1'b0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
    end else begin
      if (ar_hs) begin
        r_id_q      <= s_axi.arid;
        r_idx_q     <= addr_to_idx(s_axi.araddr[AXI_ADDR_WIDTH-1:AXI_STROBE_LEN]);
        r_fixed_q   <= (s_axi.arburst == 2'b00);
        r_size_ok_q <= (s_axi.arsize == 3'(AXI_STROBE_LEN));
        r_len_q     <= s_axi.arlen;
        r_cnt_q     <= '0;
      end
      // Fetch samples the array before any same-cycle write lands.
      if (r_state_q == R_FETCH) begin
        if (idx_in_range(r_idx_q) && r_size_ok_q) begin
          rdata_q <= mem[r_idx_q[IDX_W-1:0]];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
        rlast_q <= (r_cnt_q == r_len_q);
        rid_q   <= r_id_q;
      end
      if (r_hs && !rlast_q) begin
        r_cnt_q <= r_cnt_q + 8'd1;
        if (!r_fixed_q) r_idx_q <= idx_next(r_idx_q);
      end
    end
  end

  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rlast = rlast_q;
  assign s_axi.rid   = rid_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awuser, s_axi.aruser,
                       s_axi.awaddr[AXI_STROBE_LEN-1:0], s_axi.araddr[AXI_STROBE_LEN-1:0]};

endmodule
